// File: rtl/rename_stage.sv
// ---------------------------------------------------------------------------
// rename_stage
//
// Dual-issue register rename stage sitting directly behind decode. Each group
// carries two instructions. Their architectural registers x0..x31 are mapped
// to physical registers through a register alias table (RAT). New
// destinations are taken from a circular free list. Results are registered,
// giving one cycle of latency into dispatch. Commit hands freed physical
// registers back through two free ports.
//
// Optional feature: define RENAME_STALL_CNT_EN to add a saturating 16-bit
// counter of stall cycles on stall_cnt_o.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   en_flag_i                 decode group valid
//   opcode_k, rs1_k, rs2_k,   decoded fields of slot k (k = 1, 2)
//   rd_k, instr_k_, PCk_i
//   free_en_k, free_preg_k    commit returns physical register free_preg_k
//   stall_o                   combinational; decode holds its group while high
//   en_flag_o                 renamed group valid (registered)
//   prs1_k, prs2_k            physical sources of slot k
//   prd_k, old_prd_k          new physical destination / previous mapping of rd
//   wr_k                      slot k writes a register
//   instr_k_o, PCk_o          registered pass-through
//   stall_cnt_o               (RENAME_STALL_CNT_EN only) stall cycle count
// ---------------------------------------------------------------------------
module rename_stage #(
  parameter  int PHYS_REGS = 64,
  localparam int PW        = $clog2(PHYS_REGS),
  localparam int FL_DEPTH  = PHYS_REGS - 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_flag_i,
  input  logic [6:0]    opcode_1,
  input  logic [6:0]    opcode_2,
  input  logic [4:0]    rs1_1,
  input  logic [4:0]    rs1_2,
  input  logic [4:0]    rs2_1,
  input  logic [4:0]    rs2_2,
  input  logic [4:0]    rd_1,
  input  logic [4:0]    rd_2,
  input  logic [31:0]   instr_1_,
  input  logic [31:0]   instr_2_,
  input  logic [6:0]    PC1_i,
  input  logic [6:0]    PC2_i,
  input  logic          free_en_1,
  input  logic          free_en_2,
  input  logic [PW-1:0] free_preg_1,
  input  logic [PW-1:0] free_preg_2,
`ifdef RENAME_STALL_CNT_EN
  output logic [15:0]   stall_cnt_o,
`endif
  output logic          stall_o,
  output logic          en_flag_o,
  output logic [PW-1:0] prs1_1,
  output logic [PW-1:0] prs1_2,
  output logic [PW-1:0] prs2_1,
  output logic [PW-1:0] prs2_2,
  output logic [PW-1:0] prd_1,
  output logic [PW-1:0] prd_2,
  output logic [PW-1:0] old_prd_1,
  output logic [PW-1:0] old_prd_2,
  output logic          wr_1,
  output logic          wr_2,
  output logic [31:0]   instr_1_o,
  output logic [31:0]   instr_2_o,
  output logic [6:0]    PC1_o,
  output logic [6:0]    PC2_o
);

  localparam int HW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CW = $clog2(FL_DEPTH + 1);

  typedef logic [HW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic          en;
    logic          wr_1;
    logic          wr_2;
    logic [PW-1:0] prs1_1;
    logic [PW-1:0] prs1_2;
    logic [PW-1:0] prs2_1;
    logic [PW-1:0] prs2_2;
    logic [PW-1:0] prd_1;
    logic [PW-1:0] prd_2;
    logic [PW-1:0] old_prd_1;
    logic [PW-1:0] old_prd_2;
    logic [31:0]   instr_1;
    logic [31:0]   instr_2;
    logic [6:0]    pc_1;
    logic [6:0]    pc_2;
  } out_t;

  // Only ALU-reg, ALU-imm and loads produce a result; x0 is never a target.
  function automatic logic is_writer(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011));
  endfunction

  // Free-list pointers wrap modulo FL_DEPTH, which need not be a power of 2.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FL_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

`ifdef RENAME_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [PW-1:0] rat_q [32];
  logic [PW-1:0] rat_d [32];
  logic [PW-1:0] fl_q  [FL_DEPTH];
  logic [PW-1:0] fl_d  [FL_DEPTH];
  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  cnt_t          count_q, count_d;
  out_t          out_q, out_d;

  logic          wr_1_c, wr_2_c;
  logic [1:0]    need_c;
  logic          stall_c, accept_c;
  logic          pop_1, pop_2;
  logic [PW-1:0] alloc_1, alloc_2;
  logic          room_1, room_2;
  logic          push_1, push_2;
  logic          ovf_1, ovf_2;
  logic [1:0]    pops_c, pushes_c;
  ptr_t          hptr, tptr;

  assign stall_o = stall_c;

  always_comb begin
    wr_1_c   = is_writer(opcode_1, rd_1);
    wr_2_c   = is_writer(opcode_2, rd_2);
    need_c   = {1'b0, wr_1_c} + {1'b0, wr_2_c};
    // Stall is judged on the count before this cycle's frees land.
    stall_c  = en_flag_i && (count_q < cnt_t'(need_c));
    accept_c = en_flag_i && !stall_c;
    pop_1    = accept_c && wr_1_c;
    pop_2    = accept_c && wr_2_c;

    // Slot 2 takes the entry after slot 1's only when slot 1 allocates.
    alloc_1  = fl_q[head_q];
    alloc_2  = fl_q[wr_1_c ? ptr_inc(head_q) : head_q];

    // A free into a full list is illegal and dropped; p0 is never recycled.
    room_1   = (count_q < cnt_t'(FL_DEPTH));
    push_1   = free_en_1 && (free_preg_1 != '0) && room_1;
    ovf_1    = free_en_1 && (free_preg_1 != '0) && !room_1;
    room_2   = push_1 ? (count_q < cnt_t'(FL_DEPTH - 1)) : room_1;
    push_2   = free_en_2 && (free_preg_2 != '0) && room_2;
    ovf_2    = free_en_2 && (free_preg_2 != '0) && !room_2;

    pops_c   = {1'b0, pop_1} + {1'b0, pop_2};
    pushes_c = {1'b0, push_1} + {1'b0, push_2};

    rat_d    = rat_q;
    fl_d     = fl_q;
    out_d    = out_q;
    out_d.en = accept_c;

    if (accept_c) begin
      out_d.wr_1      = wr_1_c;
      out_d.wr_2      = wr_2_c;
      out_d.prd_1     = wr_1_c ? alloc_1 : '0;
      out_d.prd_2     = wr_2_c ? alloc_2 : '0;
      out_d.prs1_1    = rat_q[rs1_1];
      out_d.prs2_1    = rat_q[rs2_1];
      // Slot 2 must see slot 1's fresh mapping, which the RAT does not yet hold.
      out_d.prs1_2    = (wr_1_c && (rs1_2 == rd_1)) ? alloc_1 : rat_q[rs1_2];
      out_d.prs2_2    = (wr_1_c && (rs2_2 == rd_1)) ? alloc_1 : rat_q[rs2_2];
      out_d.old_prd_1 = wr_1_c ? rat_q[rd_1] : '0;
      if (!wr_2_c)
        out_d.old_prd_2 = '0;
      else if (wr_1_c && (rd_2 == rd_1))
        out_d.old_prd_2 = alloc_1;
      else
        out_d.old_prd_2 = rat_q[rd_2];
      out_d.instr_1   = instr_1_;
      out_d.instr_2   = instr_2_;
      out_d.pc_1      = PC1_i;
      out_d.pc_2      = PC2_i;
      // Slot 2 is written last so it wins when both slots target one rd.
      if (wr_1_c) rat_d[rd_1] = alloc_1;
      if (wr_2_c) rat_d[rd_2] = alloc_2;
    end

    hptr = head_q;
    if (pop_1) hptr = ptr_inc(hptr);
    if (pop_2) hptr = ptr_inc(hptr);
    head_d = hptr;

    tptr = tail_q;
    if (push_1) begin
      fl_d[tptr] = free_preg_1;
      tptr       = ptr_inc(tptr);
    end
    if (push_2) begin
      fl_d[tptr] = free_preg_2;
      tptr       = ptr_inc(tptr);
    end
    tail_d  = tptr;

    count_d = count_q - cnt_t'(pops_c) + cnt_t'(pushes_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)       rat_q[i] <= PW'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i]  <= PW'(i + 32);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= cnt_t'(FL_DEPTH);
      out_q   <= '0;
    end else begin
      rat_q   <= rat_d;
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_c ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign en_flag_o = out_q.en;
  assign wr_1      = out_q.wr_1;
  assign wr_2      = out_q.wr_2;
  assign prs1_1    = out_q.prs1_1;
  assign prs1_2    = out_q.prs1_2;
  assign prs2_1    = out_q.prs2_1;
  assign prs2_2    = out_q.prs2_2;
  assign prd_1     = out_q.prd_1;
  assign prd_2     = out_q.prd_2;
  assign old_prd_1 = out_q.old_prd_1;
  assign old_prd_2 = out_q.old_prd_2;
  assign instr_1_o = out_q.instr_1;
  assign instr_2_o = out_q.instr_2;
  assign PC1_o     = out_q.pc_1;
  assign PC2_o     = out_q.pc_2;

`ifndef SYNTHESIS
  // Commit must never return more registers than the list can hold.
  free_list_overflow: assert property (@(posedge clk) disable iff (rst) !(ovf_1 || ovf_2));
`endif

endmodule

// File: tb/tb_rename_stage.sv
module tb_rename_stage;
  localparam int PHYS_REGS = 64;
  localparam int PW        = $clog2(PHYS_REGS);

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_flag_i;
  logic [6:0]    opcode_1, opcode_2;
  logic [4:0]    rs1_1, rs1_2, rs2_1, rs2_2, rd_1, rd_2;
  logic [31:0]   instr_1_, instr_2_;
  logic [6:0]    PC1_i, PC2_i;
  logic          free_en_1, free_en_2;
  logic [PW-1:0] free_preg_1, free_preg_2;
  logic          stall_o, en_flag_o, wr_1, wr_2;
  logic [PW-1:0] prs1_1, prs1_2, prs2_1, prs2_2, prd_1, prd_2, old_prd_1, old_prd_2;
  logic [31:0]   instr_1_o, instr_2_o;
  logic [6:0]    PC1_o, PC2_o;
`ifdef RENAME_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  rename_stage #(.PHYS_REGS(PHYS_REGS)) dut (
    .clk(clk), .rst(rst), .en_flag_i(en_flag_i),
    .opcode_1(opcode_1), .opcode_2(opcode_2),
    .rs1_1(rs1_1), .rs1_2(rs1_2), .rs2_1(rs2_1), .rs2_2(rs2_2),
    .rd_1(rd_1), .rd_2(rd_2),
    .instr_1_(instr_1_), .instr_2_(instr_2_), .PC1_i(PC1_i), .PC2_i(PC2_i),
    .free_en_1(free_en_1), .free_en_2(free_en_2),
    .free_preg_1(free_preg_1), .free_preg_2(free_preg_2),
`ifdef RENAME_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .stall_o(stall_o), .en_flag_o(en_flag_o),
    .prs1_1(prs1_1), .prs1_2(prs1_2), .prs2_1(prs2_1), .prs2_2(prs2_2),
    .prd_1(prd_1), .prd_2(prd_2), .old_prd_1(old_prd_1), .old_prd_2(old_prd_2),
    .wr_1(wr_1), .wr_2(wr_2),
    .instr_1_o(instr_1_o), .instr_2_o(instr_2_o), .PC1_o(PC1_o), .PC2_o(PC2_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural map, free FIFO, and registers awaiting commit.
  int rat [32];
  int fq [$];
  int pool [$];

  logic [31:0] e_en, e_wr1, e_wr2, e_prs11, e_prs12, e_prs21, e_prs22;
  logic [31:0] e_prd1, e_prd2, e_old1, e_old2, e_in1, e_in2, e_pc1, e_pc2;
  logic [31:0] e_scnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 0) && (op == OP_ADD || op == OP_ADDI || op == OP_LW);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fq.delete();
    for (int i = 32; i < PHYS_REGS; i++) fq.push_back(i);
    pool.delete();
    {e_en, e_wr1, e_wr2, e_prs11, e_prs12, e_prs21, e_prs22} = '0;
    {e_prd1, e_prd2, e_old1, e_old2, e_in1, e_in2, e_pc1, e_pc2} = '0;
    e_scnt = 0;
  endtask

  task automatic chk_outs();
    chk("en_flag_o", en_flag_o, e_en);
    chk("wr_1", wr_1, e_wr1);
    chk("wr_2", wr_2, e_wr2);
    chk("prs1_1", prs1_1, e_prs11);
    chk("prs1_2", prs1_2, e_prs12);
    chk("prs2_1", prs2_1, e_prs21);
    chk("prs2_2", prs2_2, e_prs22);
    chk("prd_1", prd_1, e_prd1);
    chk("prd_2", prd_2, e_prd2);
    chk("old_prd_1", old_prd_1, e_old1);
    chk("old_prd_2", old_prd_2, e_old2);
    chk("instr_1_o", instr_1_o, e_in1);
    chk("instr_2_o", instr_2_o, e_in2);
    chk("PC1_o", PC1_o, e_pc1);
    chk("PC2_o", PC2_o, e_pc2);
`ifdef RENAME_STALL_CNT_EN
    chk("stall_cnt_o", stall_cnt_o, e_scnt);
`endif
  endtask

  task automatic clear_inputs();
    en_flag_i = 0; opcode_1 = 0; opcode_2 = 0;
    rs1_1 = 0; rs1_2 = 0; rs2_1 = 0; rs2_2 = 0; rd_1 = 0; rd_2 = 0;
    instr_1_ = 0; instr_2_ = 0; PC1_i = 0; PC2_i = 0;
    free_en_1 = 0; free_en_2 = 0; free_preg_1 = 0; free_preg_2 = 0;
  endtask

  // Reset takes effect immediately; outputs are checked before any clock edge.
  task automatic reset_dut();
    rst = 1;
    #1;
    model_reset();
    chk_outs();
    clear_inputs();
    #1;
    chk("stall_o_rst", stall_o, 0);
    @(posedge clk); #1;
    chk_outs();
    rst = 0;
  endtask

  task automatic set_grp(input logic en, input logic [6:0] o1, input logic [4:0] d1,
                         input logic [4:0] a1, input logic [4:0] b1,
                         input logic [6:0] o2, input logic [4:0] d2,
                         input logic [4:0] a2, input logic [4:0] b2);
    en_flag_i = en;
    opcode_1 = o1; rd_1 = d1; rs1_1 = a1; rs2_1 = b1;
    opcode_2 = o2; rd_2 = d2; rs1_2 = a2; rs2_2 = b2;
    instr_1_ = $urandom; instr_2_ = $urandom;
    PC1_i = 7'($urandom); PC2_i = 7'($urandom);
  endtask

  // One clock: check the combinational stall, advance the model, check outputs.
  task automatic do_cycle();
    bit w1, w2, st, acc;
    int need, p1, p2;
    int tmp [32];
    #1;
    w1   = writes(opcode_1, rd_1);
    w2   = writes(opcode_2, rd_2);
    need = int'(w1) + int'(w2);
    st   = en_flag_i && (fq.size() < need);
    acc  = en_flag_i && !st;
    chk("stall_o", stall_o, st);
    if (acc) begin
      // Sequential semantics: slot 2 is renamed as if slot 1 had already retired into the map.
      tmp = rat;
      p1 = w1 ? fq.pop_front() : 0;
      e_prs11 = rat[rs1_1];
      e_prs21 = rat[rs2_1];
      e_old1  = w1 ? rat[rd_1] : 0;
      if (w1) tmp[rd_1] = p1;
      p2 = w2 ? fq.pop_front() : 0;
      e_prs12 = tmp[rs1_2];
      e_prs22 = tmp[rs2_2];
      e_old2  = w2 ? tmp[rd_2] : 0;
      if (w2) tmp[rd_2] = p2;
      rat = tmp;
      e_prd1 = p1; e_prd2 = p2; e_wr1 = w1; e_wr2 = w2;
      e_in1 = instr_1_; e_in2 = instr_2_; e_pc1 = PC1_i; e_pc2 = PC2_i;
      if (w1) pool.push_back(e_old1);
      if (w2) pool.push_back(e_old2);
    end
    e_en = acc;
    if (free_en_1 && free_preg_1 != 0) fq.push_back(free_preg_1);
    if (free_en_2 && free_preg_2 != 0) fq.push_back(free_preg_2);
    if (st && e_scnt != 32'hFFFF) e_scnt++;
    @(posedge clk); #1;
    chk_outs();
  endtask

  task automatic pick_frees(input int pct);
    int k;
    free_en_1 = 0; free_en_2 = 0; free_preg_1 = 0; free_preg_2 = 0;
    if (pool.size() > 0 && $urandom_range(99, 0) < pct) begin
      k = $urandom_range(pool.size() - 1, 0);
      free_en_1 = 1; free_preg_1 = PW'(pool[k]); pool.delete(k);
    end
    if (pool.size() > 0 && $urandom_range(99, 0) < pct) begin
      k = $urandom_range(pool.size() - 1, 0);
      free_en_2 = 1; free_preg_2 = PW'(pool[k]); pool.delete(k);
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = OP_ADD; ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_SW;  ops[4] = 7'd0;    ops[5] = OP_BEQ;
    clear_inputs();
    rst = 0;
    #2;
    reset_dut();

    // ADD x5,x1,x2 / ADDI x6,x5: slot 2 sees slot 1's new register.
    set_grp(1, OP_ADD, 5, 1, 2, OP_ADDI, 6, 5, 0);
    do_cycle();
    chk("t1_prd_1", prd_1, 32);
    chk("t1_prd_2", prd_2, 33);
    chk("t1_prs1_2", prs1_2, 32);
    chk("t1_old_prd_1", old_prd_1, 5);

    // Both slots target x7.
    reset_dut();
    set_grp(1, OP_ADD, 7, 1, 2, OP_LW, 7, 3, 0);
    do_cycle();
    chk("t2_prd_1", prd_1, 32);
    chk("t2_prd_2", prd_2, 33);
    chk("t2_old_prd_2", old_prd_2, 32);
    set_grp(1, OP_ADD, 8, 7, 7, OP_BEQ, 0, 7, 1);
    do_cycle();
    chk("t2_read_x7", prs1_1, 33);

    // Drain all 32 free registers, then a further 2-write group must stall.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      set_grp(1, OP_ADD, 5'((2 * i) % 31 + 1), 5'(i), 5'(i + 1),
              OP_ADDI, 5'((2 * i + 1) % 31 + 1), 5'(i + 2), 0);
      do_cycle();
    end
    set_grp(1, OP_ADD, 12, 1, 2, OP_ADD, 13, 3, 4);
    #1 chk("t3_stall_o", stall_o, 1);
    do_cycle();
    chk("t3_en_flag_o", en_flag_o, 0);

    // Empty list: a free arriving with the group does not help until next cycle.
    for (int k = 0; k < pool.size(); k++)
      if (pool[k] == 5) begin pool.delete(k); break; end
    set_grp(1, OP_ADDI, 9, 1, 0, 7'd0, 0, 0, 0);
    free_en_1 = 1; free_preg_1 = 5;
    #1 chk("t4_stall_o", stall_o, 1);
    do_cycle();
    chk("t4_en_held", en_flag_o, 0);
    free_en_1 = 0; free_preg_1 = 0;
    do_cycle();
    chk("t4_en_flag_o", en_flag_o, 1);
    chk("t4_prd_1", prd_1, 5);

    // Non-writing groups consume nothing even with an empty list.
    set_grp(1, OP_SW, 3, 0, 4, OP_ADD, 0, 0, 6);
    do_cycle();
    chk("t5_wr_1", wr_1, 0);
    chk("t5_prd_2", prd_2, 0);
    chk("t5_x0_src", prs1_1, 0);
    set_grp(0, OP_ADD, 10, 1, 2, OP_ADD, 11, 3, 4);
    do_cycle();
    set_grp(1, 7'd0, 9, 1, 2, OP_BEQ, 4, 5, 6);
    do_cycle();
    pick_frees(100);
    set_grp(0, OP_ADD, 10, 1, 2, OP_ADD, 11, 3, 4);
    do_cycle();
    free_en_1 = 0; free_en_2 = 0;
    set_grp(1, OP_ADD, 10, 1, 2, OP_ADD, 11, 10, 4);
    do_cycle();

    // Reset while a group is being accepted.
    set_grp(1, OP_ADD, 14, 1, 2, OP_ADD, 15, 3, 4);
    reset_dut();
    set_grp(1, OP_ADD, 10, 5, 0, OP_ADDI, 11, 6, 0);
    do_cycle();
    chk("t6_prd_1", prd_1, 32);
    chk("t6_prs1_1", prs1_1, 5);
    chk("t6_old_prd_1", old_prd_1, 10);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] d1;
      d1 = 5'($urandom);
      set_grp(($urandom_range(3, 0) != 0), ops[$urandom_range(5, 0)], d1,
              5'($urandom), 5'($urandom), ops[$urandom_range(5, 0)],
              ($urandom_range(3, 0) == 0) ? d1 : 5'($urandom),
              ($urandom_range(1, 0) == 0) ? d1 : 5'($urandom), 5'($urandom));
      pick_frees(45);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
